inst_fetch: RTL and testbench



---
 rtl/inst_fetch_pkg.sv | 14 +
 rtl/inst_fetch_if.sv | 26 ++
 rtl/inst_fetch_ctrl.sv | 85 ++++++++
 rtl/inst_fetch.sv | 70 +++++++
 tb/tb_inst_fetch.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the uDLX instruction-fetch stage.
package inst_fetch_pkg;

  localparam int unsigned PcWidth            = 20;
  localparam int unsigned InstrWidth         = 32;
  localparam int unsigned PcIncrementDefault = 4;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StFull = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, decode-side outputs, execute redirect.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic [PcWidth-1:0]    inst_mem_addr;
  logic                  inst_mem_rd_en;
  logic [InstrWidth-1:0] inst_mem_data;
  logic                  inst_mem_valid;
  logic                  stall;
  logic                  branch_taken;
  logic [PcWidth-1:0]    branch_target;
  logic [InstrWidth-1:0] instruction;
  logic [PcWidth-1:0]    new_pc;
  logic                  inst_valid;

  modport master (
    output inst_mem_addr, inst_mem_rd_en, instruction, new_pc, inst_valid,
    input  inst_mem_data, inst_mem_valid, stall, branch_taken, branch_target
  );

  modport slave (
    input  inst_mem_addr, inst_mem_rd_en, instruction, new_pc, inst_valid,
    output inst_mem_data, inst_mem_valid, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch FSM (REQ/WAIT/FULL) plus the flag that drops responses made stale by a redirect.
module inst_fetch_ctrl
  import inst_fetch_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_mem_valid,
  input  logic i_stall,
  input  logic i_branch,
  output logic o_rd_en,
  output logic o_load,
  output logic o_pc_inc,
  output logic o_pc_redirect,
  output logic o_clear_valid
);

  fetch_state_e r_state, w_state_nxt;
  logic         r_discard, w_discard_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StReq;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    o_load        = 1'b0;
    o_pc_inc      = 1'b0;
    o_pc_redirect = 1'b0;
    o_clear_valid = 1'b0;
    if (i_branch) begin
      o_pc_redirect = 1'b1;
      o_clear_valid = 1'b1;
      unique case (r_state)
        StReq: begin
          // The request issued this cycle is still in flight.
          w_discard_nxt = 1'b1;
          w_state_nxt   = StWait;
        end
        StWait: begin
          if (i_mem_valid) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = StReq;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end
        StFull:  w_state_nxt = StReq;
        default: w_state_nxt = StReq;
      endcase
    end else begin
      unique case (r_state)
        StReq: w_state_nxt = StWait;
        StWait: begin
          if (i_mem_valid) begin
            if (r_discard) begin
              w_discard_nxt = 1'b0;
              w_state_nxt   = StReq;
            end else begin
              o_load      = 1'b1;
              o_pc_inc    = 1'b1;
              w_state_nxt = StFull;
            end
          end
        end
        StFull: begin
          if (!i_stall) begin
            o_clear_valid = 1'b1;
            w_state_nxt   = StReq;
          end
        end
        default: w_state_nxt = StReq;
      endcase
    end
  end

  assign o_rd_en = (r_state == StReq) && !i_rst;

endmodule

// File: rtl/inst_fetch.sv
// uDLX instruction-fetch stage: PC and IF/ID output registers around the fetch FSM.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned PcIncrement = PcIncrementDefault
) (
  input logic          i_clk,
  input logic          i_rst,
  inst_fetch_if.master io_bus
);

  localparam logic [PcWidth-1:0] PcStep = PcWidth'(PcIncrement);

  logic [PcWidth-1:0]    r_pc;
  logic [InstrWidth-1:0] r_instruction;
  logic [PcWidth-1:0]    r_new_pc;
  logic                  r_inst_valid;

  logic [PcWidth-1:0] w_pc_plus;
  logic               w_rd_en;
  logic               w_load;
  logic               w_pc_inc;
  logic               w_pc_redirect;
  logic               w_clear_valid;

  inst_fetch_ctrl u_ctrl (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_mem_valid   (io_bus.inst_mem_valid),
    .i_stall       (io_bus.stall),
    .i_branch      (io_bus.branch_taken),
    .o_rd_en       (w_rd_en),
    .o_load        (w_load),
    .o_pc_inc      (w_pc_inc),
    .o_pc_redirect (w_pc_redirect),
    .o_clear_valid (w_clear_valid)
  );

  // Wraps modulo 2^PcWidth.
  assign w_pc_plus = r_pc + PcStep;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= '0;
      r_instruction <= '0;
      r_new_pc      <= '0;
      r_inst_valid  <= 1'b0;
    end else begin
      if (w_pc_redirect) begin
        r_pc <= io_bus.branch_target;
      end else if (w_pc_inc) begin
        r_pc <= w_pc_plus;
      end
      if (w_load) begin
        r_instruction <= io_bus.inst_mem_data;
        r_new_pc      <= w_pc_plus;
        r_inst_valid  <= 1'b1;
      end else if (w_clear_valid) begin
        r_inst_valid  <= 1'b0;
      end
    end
  end

  assign io_bus.inst_mem_addr  = r_pc;
  assign io_bus.inst_mem_rd_en = w_rd_en;
  assign io_bus.instruction    = r_instruction;
  assign io_bus.new_pc         = r_new_pc;
  assign io_bus.inst_valid     = r_inst_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a variable-latency instruction-memory model.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    return {12'hABC, a};
  endfunction

  // Memory model: one outstanding read, response mem_lat cycles after the request cycle.
  int          mem_lat = 1;
  int          cyc_cnt = 0;
  logic        pend    = 1'b0;
  logic [19:0] pend_addr;
  int          pend_cnt;
  logic        smp_rst, smp_req;
  logic [19:0] smp_addr;
  logic [19:0] req_addr_q[$];
  int          req_cyc_q[$];

  always @(posedge clk) begin
    cyc_cnt++;
    smp_rst  = rst;
    smp_req  = bus.inst_mem_rd_en;
    smp_addr = bus.inst_mem_addr;
    if (smp_req) begin
      req_addr_q.push_back(smp_addr);
      req_cyc_q.push_back(cyc_cnt);
    end
    #1;
    bus.inst_mem_valid = 1'b0;
    if (smp_rst) begin
      pend = 1'b0;
    end else begin
      if (smp_req) begin
        pend      = 1'b1;
        pend_addr = smp_addr;
        pend_cnt  = mem_lat;
      end
      if (pend) begin
        if (pend_cnt <= 1) begin
          bus.inst_mem_valid = 1'b1;
          bus.inst_mem_data  = mem_word(pend_addr);
          pend               = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (bus.inst_valid !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    check_eq("valid_within_budget", {31'b0, bus.inst_valid}, 32'd1);
  endtask

  int s;

  initial begin
    rst                = 1'b1;
    bus.stall          = 1'b0;
    bus.branch_taken   = 1'b0;
    bus.branch_target  = '0;
    bus.inst_mem_valid = 1'b0;
    bus.inst_mem_data  = '0;

    // Reset state
    cyc();
    cyc();
    check_eq("rst_rd_en", {31'b0, bus.inst_mem_rd_en}, 32'd0);
    check_eq("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check_eq("rst_instr", bus.instruction, 32'd0);
    check_eq("rst_new_pc", {12'b0, bus.new_pc}, 32'd0);
    check_eq("rst_addr", {12'b0, bus.inst_mem_addr}, 32'd0);
    rst = 1'b0;

    // Sequential fetch, 1-cycle memory
    for (int k = 0; k < 3; k++) begin
      wait_valid(10);
      check_eq("seq_instr", bus.instruction, mem_word(20'(4 * k)));
      check_eq("seq_new_pc", {12'b0, bus.new_pc}, 32'(4 * k + 4));
      cyc();
      check_eq("seq_pulse", {31'b0, bus.inst_valid}, 32'd0);
    end
    check_eq("seq_req_count", req_addr_q.size(), 32'd3);
    check_eq("seq_req0", {12'b0, req_addr_q[0]}, 32'h0);
    check_eq("seq_req1", {12'b0, req_addr_q[1]}, 32'h4);
    check_eq("seq_req2", {12'b0, req_addr_q[2]}, 32'h8);
    check_eq("seq_spacing01", req_cyc_q[1] - req_cyc_q[0], 32'd3);
    check_eq("seq_spacing12", req_cyc_q[2] - req_cyc_q[1], 32'd3);

    // Stall for 5 cycles while FULL
    bus.stall = 1'b1;
    wait_valid(10);
    s = req_addr_q.size();
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", {31'b0, bus.inst_valid}, 32'd1);
      check_eq("stall_instr", bus.instruction, mem_word(20'hC));
      check_eq("stall_new_pc", {12'b0, bus.new_pc}, 32'h10);
      check_eq("stall_no_req", {31'b0, bus.inst_mem_rd_en}, 32'd0);
      cyc();
    end
    check_eq("stall_req_count", req_addr_q.size(), 32'(s));
    bus.stall = 1'b0;
    cyc();
    check_eq("unstall_rd_en", {31'b0, bus.inst_mem_rd_en}, 32'd1);
    check_eq("unstall_addr", {12'b0, bus.inst_mem_addr}, 32'h10);

    // Redirect in REQ, 3-cycle memory: response for 0x10 must be dropped
    s                 = req_addr_q.size();
    mem_lat           = 3;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 20'h100;
    cyc();
    bus.branch_taken  = 1'b0;
    wait_valid(20);
    check_eq("br_req_instr", bus.instruction, mem_word(20'h100));
    check_eq("br_req_new_pc", {12'b0, bus.new_pc}, 32'h104);
    check_eq("br_req_count", req_addr_q.size(), 32'(s + 2));
    check_eq("br_req_stale", {12'b0, req_addr_q[s]}, 32'h10);
    check_eq("br_req_target", {12'b0, req_addr_q[s + 1]}, 32'h100);

    // Redirect coincident with the response in WAIT
    mem_lat = 1;
    cyc();
    cyc();
    check_eq("br_wait_resp_present", {31'b0, bus.inst_mem_valid}, 32'd1);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 20'h200;
    cyc();
    bus.branch_taken  = 1'b0;
    check_eq("br_wait_valid", {31'b0, bus.inst_valid}, 32'd0);
    check_eq("br_wait_rd_en", {31'b0, bus.inst_mem_rd_en}, 32'd1);
    check_eq("br_wait_addr", {12'b0, bus.inst_mem_addr}, 32'h200);
    wait_valid(10);
    check_eq("br_wait_instr", bus.instruction, mem_word(20'h200));
    check_eq("br_wait_new_pc", {12'b0, bus.new_pc}, 32'h204);

    // Redirect while FULL and stalled, to the top of the address space
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 20'hFFFFC;
    cyc();
    bus.branch_taken  = 1'b0;
    bus.stall         = 1'b0;
    check_eq("br_full_valid", {31'b0, bus.inst_valid}, 32'd0);
    check_eq("br_full_rd_en", {31'b0, bus.inst_mem_rd_en}, 32'd1);
    check_eq("br_full_addr", {12'b0, bus.inst_mem_addr}, 32'hFFFFC);
    wait_valid(10);
    check_eq("wrap_instr", bus.instruction, mem_word(20'hFFFFC));
    check_eq("wrap_new_pc", {12'b0, bus.new_pc}, 32'h0);
    cyc();
    check_eq("wrap_rd_en", {31'b0, bus.inst_mem_rd_en}, 32'd1);
    check_eq("wrap_addr", {12'b0, bus.inst_mem_addr}, 32'h0);

    // Reset during WAIT
    mem_lat = 3;
    cyc();
    rst = 1'b1;
    cyc();
    check_eq("midrst_rd_en", {31'b0, bus.inst_mem_rd_en}, 32'd0);
    check_eq("midrst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check_eq("midrst_instr", bus.instruction, 32'd0);
    check_eq("midrst_new_pc", {12'b0, bus.new_pc}, 32'd0);
    check_eq("midrst_addr", {12'b0, bus.inst_mem_addr}, 32'd0);
    cyc();
    check_eq("midrst_rd_en_hold", {31'b0, bus.inst_mem_rd_en}, 32'd0);
    rst     = 1'b0;
    mem_lat = 1;
    #1;
    check_eq("postrst_rd_en", {31'b0, bus.inst_mem_rd_en}, 32'd1);
    check_eq("postrst_addr", {12'b0, bus.inst_mem_addr}, 32'h0);
    wait_valid(10);
    check_eq("postrst_instr", bus.instruction, mem_word(20'h0));
    check_eq("postrst_new_pc", {12'b0, bus.new_pc}, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
